// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over back-to-back
// gate windows of N clk cycles and reports the count of each completed window.
//
// Optional feature, enabled by defining FREQ_METER_BCD_EN:
//   a sequential double-dabble converter that turns each new freq into
//   8-digit packed BCD (bcd / bcd_valid). Its FSM state is visible on
//   bcd_state (0 = IDLE, 1 = SHIFT, 2 = DONE).
//
// Handshake: freq_valid and bcd_valid are single-cycle strobes with no ready
// input. The matching data (freq/overflow, bcd) is registered and stays stable
// until the next strobe, so a consumer may sample it on the strobe or later.
module freq_meter #(
    parameter int N = 100_000_000,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    output logic [W-1:0] freq,
    output logic         freq_valid,
    output logic         overflow
`ifdef FREQ_METER_BCD_EN
    ,
    output logic [31:0]  bcd,
    output logic         bcd_valid,
    output logic [1:0]   bcd_state
`endif
);

    localparam int           GW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [GW-1:0] GLAST = GW'(N - 1);
    localparam logic [W-1:0]  EMAX  = {W{1'b1}};

    logic          s1, s2, s3;
    logic          rise;
    logic [GW-1:0] gcnt;
    logic          close;
    logic [W-1:0]  ecnt;
    logic          ecnt_full;
    logic          ovf_w;

    assign rise      = s2 & ~s3;
    assign close     = (gcnt == GLAST);
    assign ecnt_full = (ecnt == EMAX);

    // Two-flop synchronizer followed by a delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Gate counter: 0..N-1, wrapping with no dead cycle between windows.
    always_ff @(posedge clk) begin
        if (rst) begin
            gcnt <= '0;
        end else if (close) begin
            gcnt <= '0;
        end else begin
            gcnt <= gcnt + 1'b1;
        end
    end

    // Edge counting with saturation; at window close the count (including a
    // rise in the close cycle itself) is published and the counter restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            ecnt       <= '0;
            ovf_w      <= 1'b0;
            freq       <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= close;
            if (close) begin
                freq     <= (rise && !ecnt_full) ? ecnt + 1'b1 : ecnt;
                overflow <= ovf_w | (rise & ecnt_full);
                ecnt     <= '0;
                ovf_w    <= 1'b0;
            end else if (rise) begin
                if (ecnt_full) begin
                    ovf_w <= 1'b1;
                end else begin
                    ecnt <= ecnt + 1'b1;
                end
            end
        end
    end

`ifdef FREQ_METER_BCD_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } bcd_st_t;

    // Comparison width large enough for both freq and the 8-digit ceiling.
    localparam int             CW      = (W > 27) ? W : 27;
    localparam logic [CW-1:0]  BCD_MAX = CW'(99_999_999);
    localparam int             BW      = $clog2(W + 1);
    localparam logic [BW-1:0]  BLAST   = BW'(W - 1);

    bcd_st_t       st;
    logic [W-1:0]  bin;
    logic [31:0]   work;
    logic [BW-1:0] bit_cnt;
    logic [CW-1:0] freq_ext;
    logic [W-1:0]  load_val;
    logic [31:0]   adj;
    logic [31:0]   work_next;

    assign freq_ext  = CW'(freq);
    // Values above 8 digits are clamped to the largest displayable number.
    assign load_val  = (freq_ext > BCD_MAX) ? W'(BCD_MAX) : freq;
    assign work_next = {adj[30:0], bin[W-1]};
    assign bcd_state = st;

    // Add-3 correction on every BCD digit that is 5 or more before the shift.
    always_comb begin
        adj = work;
        for (int i = 0; i < 8; i++) begin
            if (work[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Double-dabble FSM: load on freq_valid, W shift cycles, then the
    // DONE cycle presents the freshly registered bcd with bcd_valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= S_IDLE;
            bin       <= '0;
            work      <= '0;
            bit_cnt   <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (freq_valid) begin
                        bin     <= load_val;
                        work    <= '0;
                        bit_cnt <= '0;
                        st      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work    <= work_next;
                    bin     <= bin << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BLAST) begin
                        bcd       <= work_next;
                        bcd_valid <= 1'b1;
                        st        <= S_DONE;
                    end
                end
                S_DONE: begin
                    st <= S_IDLE;
                end
                default: begin
                    st <= S_IDLE;
                end
            endcase
        end
    end
`endif

endmodule
